// File: rtl/pe_drain_pkg.sv
// Shared definitions for the PE array drain block: FSM encoding,
// default column width and the LAT/ROWS counter width.
package pe_drain_pkg;

  localparam int DW_DEF = 32;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  // A latency of 0 behaves as a latency of 1.
  function automatic logic [CNT_W-1:0] eff_lat(input logic [CNT_W-1:0] lat);
    return (lat == '0) ? CNT_W'(1) : lat;
  endfunction

endpackage

// File: rtl/sum_fifo.sv
// First-word-fall-through FIFO with a registered read-data output.
// The head entry is always mirrored into o_dout, so data is visible the
// cycle after it is pushed into an empty FIFO.
module sum_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_dout;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_next;

  // Accept a pop only with data present; accept a push when room exists
  // or the head is leaving in the same cycle.
  always_comb begin
    w_full    = (r_count == CW'(DEPTH));
    w_empty   = (r_count == '0);
    w_pop     = i_pop && !w_empty;
    w_push    = i_push && (!w_full || w_pop);
    w_rd_next = w_pop ? (r_rd + 1'b1) : r_rd;
  end

  // Storage, pointers, occupancy and the registered head copy.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Next head is either the word being written this cycle or a stored one.
      if (w_push && (r_wr == w_rd_next)) r_dout <= i_din;
      else                               r_dout <= r_mem[w_rd_next];
    end
  end

  assign o_dout  = r_dout;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/pe_array_drain.sv
// Drains the bottom row of a systolic PE array: de-skews the staggered
// column partial sums into whole rows, queues them in a small FIFO and
// hands them out over a valid/ready interface.
module pe_array_drain
  import pe_drain_pkg::*;
#(
  parameter int NUM   = 16,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [CNT_W-1:0]   ROWS,
  input  logic [CNT_W-1:0]   LAT,
  input  logic [NUM*DW-1:0]  in_sum,
  output logic [NUM*DW-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int CAPW = $clog2(NUM + 256) + 1;
  localparam int CW   = $clog2(DEPTH) + 1;

  state_t            r_state;
  logic [CNT_W-1:0]  r_lat_cnt;
  logic [CNT_W-1:0]  r_rows;
  logic [CAPW-1:0]   r_cap_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_overflow;

  logic [NUM*DW-1:0] w_aligned;
  logic [NUM*DW-1:0] w_dout;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic              w_cap_last;
  logic [CW-1:0]     w_count;

  // Column j is delayed NUM-1-j cycles so every column of a row lines up
  // with the undelayed last column.
  for (genvar j = 0; j < NUM; j++) begin : g_col
    if (j == NUM - 1) begin : g_pass
      assign w_aligned[j*DW +: DW] = in_sum[j*DW +: DW];
    end else begin : g_dly
      localparam int unsigned STAGES = NUM - 1 - j;
      logic [DW-1:0] r_stage [STAGES];

      // Free-running shift chain for this column, independent of job state.
      always_ff @(posedge CLK) begin
        if (!RESET) begin
          for (int unsigned k = 0; k < STAGES; k++) r_stage[k] <= '0;
        end else begin
          r_stage[0] <= in_sum[j*DW +: DW];
          for (int unsigned k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
        end
      end

      assign w_aligned[j*DW +: DW] = r_stage[STAGES-1];
    end
  end

  // Capture window spans NUM-1+ROWS cycles; only the last ROWS of them
  // carry a fully aligned row.
  always_comb begin
    w_push     = (r_state == ST_CAPTURE) && (r_cap_cnt >= CAPW'(NUM - 1));
    w_cap_last = (r_cap_cnt == (CAPW'(NUM - 2) + CAPW'(r_rows)));
    w_pop      = out_ready && !w_empty;
    w_drop     = w_push && w_full && !w_pop;
  end

  sum_fifo #(
    .W     (NUM * DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_push  (w_push),
    .i_din   (w_aligned),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Job sequencing with registered busy/done/overflow.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_lat_cnt  <= '0;
      r_rows     <= '0;
      r_cap_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_overflow <= 1'b0;
            if (ROWS == '0) begin
              r_done <= 1'b1;
            end else begin
              r_rows    <= ROWS;
              r_cap_cnt <= '0;
              r_busy    <= 1'b1;
              // WAIT covers cycles 1..LAT-1, so a latency of 1 leaves it empty
              // and the capture window has to open in cycle 1 directly.
              if (eff_lat(LAT) == CNT_W'(1)) begin
                r_state <= ST_CAPTURE;
              end else begin
                r_lat_cnt <= eff_lat(LAT) - CNT_W'(1);
                r_state   <= ST_WAIT;
              end
            end
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == CNT_W'(1)) r_state <= ST_CAPTURE;
          else                        r_lat_cnt <= r_lat_cnt - CNT_W'(1);
        end
        ST_CAPTURE: begin
          if (w_cap_last) r_state   <= ST_FLUSH;
          else            r_cap_cnt <= r_cap_cnt + 1'b1;
        end
        ST_FLUSH: begin
          // Leave as the last queued row is taken, so done lines up with empty.
          if (w_empty || ((w_count == CW'(1)) && w_pop)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_data  = w_dout;
  assign out_valid = !w_empty;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_pe_array_drain.sv
// Scoreboard bench for pe_array_drain with NUM=4, DEPTH=4: expected rows are
// queued at job start and a monitor pops them on every handshake.
module tb_pe_array_drain;

  localparam int NUM   = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int W     = NUM * DW;

  logic          CLK       = 1'b0;
  logic          RESET     = 1'b0;
  logic          START     = 1'b0;
  logic [7:0]    ROWS      = '0;
  logic [7:0]    LAT       = '0;
  logic [W-1:0]  in_sum    = '0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic          overflow;

  int            cyc = 0;
  int            rel = 0;
  int            f_c0 = 0, f_lat = 1, f_rows = 0, f_tag = 0;
  int            errors = 0;
  int            checks = 0;
  logic [W-1:0]  sb [$];
  logic          prev_hold = 1'b0;
  logic [W-1:0]  prev_data = '0;

  pe_array_drain #(.NUM(NUM), .DW(DW), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .ROWS      (ROWS),
    .LAT       (LAT),
    .in_sum    (in_sum),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  function automatic logic [DW-1:0] colval(int tag, int r, int j);
    return DW'(tag * 16777216 + r * NUM + j + 1);
  endfunction

  function automatic logic [W-1:0] rowval(int tag, int r);
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < NUM; j++) v[j*DW +: DW] = colval(tag, r, j);
    return v;
  endfunction

  // Skewed array output: column j of row r appears in cycle LAT+r+j.
  always @(posedge CLK) begin
    #1;
    for (int j = 0; j < NUM; j++) begin
      int c, r;
      c = cyc - f_c0;
      r = c - f_lat - j;
      if (r >= 0 && r < f_rows) in_sum[j*DW +: DW] = colval(f_tag, r, j);
      else                      in_sum[j*DW +: DW] = 32'hEEEE_0000 | DW'(j);
    end
  end

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, rel);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    chk(name, W'(act), W'(exp));
  endtask

  // Monitor: ordered row check on handshake and hold stability under backpressure.
  always @(negedge CLK) begin
    if (!RESET) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk1("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_row: got %h expected none", out_data);
        end else begin
          chk("row_order", out_data, sb.pop_front());
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic start_job(int lat_pin, int lat_eff, int rows, int tag, int nexp);
    @(posedge CLK); #1;
    START  = 1'b1;
    LAT    = 8'(lat_pin);
    ROWS   = 8'(rows);
    f_c0   = cyc;
    f_lat  = lat_eff;
    f_rows = rows;
    f_tag  = tag;
    rel    = 0;
    for (int r = 0; r < nexp; r++) sb.push_back(rowval(tag, r));
  endtask

  task automatic adv(int c);
    while (rel < c) begin
      @(posedge CLK); rel++; #1;
      START = 1'b0;
    end
  endtask

  task automatic at(int c);
    adv(c);
    @(negedge CLK);
  endtask

  task automatic run_basic(string p);
    out_ready = 1'b1;
    start_job(3, 3, 2, 0, 2);
    @(negedge CLK);
    chk1({p, "_busy_c0"}, busy, 1'b0);
    at(1); chk1({p, "_busy_c1"}, busy, 1'b1);
    at(6); chk1({p, "_valid_c6"}, out_valid, 1'b0);
    at(7); chk1({p, "_valid_c7"}, out_valid, 1'b1);
           chk({p, "_row0_c7"}, out_data, 128'h00000004_00000003_00000002_00000001);
    at(8); chk({p, "_row1_c8"}, out_data, 128'h00000008_00000007_00000006_00000005);
           chk1({p, "_done_c8"}, done, 1'b0);
           chk1({p, "_busy_c8"}, busy, 1'b1);
    at(9); chk1({p, "_done_c9"}, done, 1'b1);
           chk1({p, "_busy_c9"}, busy, 1'b0);
           chk1({p, "_valid_c9"}, out_valid, 1'b0);
           chk1({p, "_ovf_c9"}, overflow, 1'b0);
    at(10); chk1({p, "_done_c10"}, done, 1'b0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ovf", overflow, 1'b0);
    chk("rst_data", out_data, '0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);

    // Basic drain
    run_basic("A");

    // Backpressure: four rows held until cycle 20
    start_job(2, 2, 4, 1, 4);
    out_ready = 1'b0;
    at(5);  chk1("B_valid_c5", out_valid, 1'b0);
    at(6);  chk1("B_valid_c6", out_valid, 1'b1);
    at(19); chk1("B_valid_c19", out_valid, 1'b1);
            chk("B_head_c19", out_data, 128'h01000004_01000003_01000002_01000001);
            chk1("B_busy_c19", busy, 1'b1);
            chk1("B_done_c19", done, 1'b0);
            chk1("B_ovf_c19", overflow, 1'b0);
    adv(20); out_ready = 1'b1;
    at(20);
    at(23); chk1("B_busy_c23", busy, 1'b1);
            chk1("B_done_c23", done, 1'b0);
    at(24); chk1("B_done_c24", done, 1'b1);
            chk1("B_busy_c24", busy, 1'b0);
            chk1("B_ovf_c24", overflow, 1'b0);
    at(26);

    // Overflow with LAT=0 (acts as 1): rows 4 and 5 are dropped
    start_job(0, 1, 6, 2, 4);
    out_ready = 1'b0;
    at(4);  chk1("C_valid_c4", out_valid, 1'b0);
    at(5);  chk1("C_valid_c5", out_valid, 1'b1);
            chk("C_head_c5", out_data, 128'h02000004_02000003_02000002_02000001);
    at(8);  chk1("C_ovf_c8", overflow, 1'b0);
    at(9);  chk1("C_ovf_c9", overflow, 1'b1);
            chk1("C_busy_c9", busy, 1'b1);
    adv(12); out_ready = 1'b1;
    at(15); chk1("C_busy_c15", busy, 1'b1);
    at(16); chk1("C_done_c16", done, 1'b1);
            chk1("C_busy_c16", busy, 1'b0);
            chk1("C_ovf_c16", overflow, 1'b1);
    at(17); chk1("C_ovf_sticky_c17", overflow, 1'b1);

    // Mid-job reset during CAPTURE with overflow already set
    start_job(3, 3, 6, 3, 0);
    out_ready = 1'b0;
    at(1);  chk1("D_ovf_clr_c1", overflow, 1'b0);
            chk1("D_busy_c1", busy, 1'b1);
    adv(11); RESET = 1'b0;
    @(negedge CLK);
            chk1("D_ovf_c11", overflow, 1'b1);
            chk1("D_busy_c11", busy, 1'b1);
    adv(12); RESET = 1'b1;
    @(negedge CLK);
            chk1("D_busy_c12", busy, 1'b0);
            chk1("D_valid_c12", out_valid, 1'b0);
            chk1("D_ovf_c12", overflow, 1'b0);
            chk1("D_done_c12", done, 1'b0);
    at(13); chk1("D_done_c13", done, 1'b0);
    at(14); chk1("D_done_c14", done, 1'b0);
            chk1("D_busy_c14", busy, 1'b0);
    run_basic("R");

    // START with ROWS=0
    start_job(4, 4, 0, 4, 0);
    out_ready = 1'b1;
    @(negedge CLK);
    chk1("E_busy_c0", busy, 1'b0);
    at(1); chk1("E_done_c1", done, 1'b1);
           chk1("E_busy_c1", busy, 1'b0);
    at(2); chk1("E_done_c2", done, 1'b0);
           chk1("E_busy_c2", busy, 1'b0);
    at(3);

    // START while busy is ignored
    start_job(2, 2, 1, 5, 1);
    at(1); chk1("F_busy_c1", busy, 1'b1);
    adv(2); START = 1'b1; ROWS = 8'd5; LAT = 8'd9;
    @(negedge CLK);
    at(5); chk1("F_valid_c5", out_valid, 1'b0);
    at(6); chk1("F_valid_c6", out_valid, 1'b1);
           chk("F_row0_c6", out_data, 128'h05000004_05000003_05000002_05000001);
    at(7); chk1("F_done_c7", done, 1'b1);
           chk1("F_busy_c7", busy, 1'b0);
           chk1("F_valid_c7", out_valid, 1'b0);
    at(8); chk1("F_busy_c8", busy, 1'b0);
           chk1("F_done_c8", done, 1'b0);
           chk1("F_valid_c8", out_valid, 1'b0);
    at(12);

    chk("sb_empty", W'(sb.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
